// File: rtl/medfilter_frame_monitor.sv
// Frame sequencer and result monitor for the median filter output stream.
// Issues run, counts output strobes to one frame and keeps position, checksum, extremes, cycles, overrun and timeout.
module medfilter_frame_monitor #(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 19,
    parameter int SUM_W      = 32,
    parameter int CYC_W      = 32,
    parameter int TIMEOUT    = 2**24,
    parameter int CONTINUOUS = 0,
    localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start_sig,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              run,
    output logic              frame_done,
    output logic              busy,
    output logic [CNT_W-1:0]  pix_cnt,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [SUM_W-1:0]  checksum,
    output logic [DATA_W-1:0] pix_min,
    output logic [DATA_W-1:0] pix_max,
    output logic [CYC_W-1:0]  cycle_cnt,
    output logic              overrun,
    output logic              timeout
);

    // state | meaning
    // IDLE  | waiting for Start_sig, results held
    // RUN   | filter running, pixels accepted
    // DONE  | one-cycle frame completion, frame_done high
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(TIMEOUT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    state_t state;
    logic   start_frame;
    logic   last_pix;

    always_comb begin
        start_frame = 1'b0;
        if (Start_sig) begin
            if (state == IDLE)
                start_frame = 1'b1;
            else if (state == DONE && CONTINUOUS != 0)
                start_frame = 1'b1;
        end
    end

    assign last_pix = pix_valid && (pix_cnt == LAST_PIX);
    assign run      = (state == RUN);
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            checksum   <= '0;
            pix_min    <= '1;
            pix_max    <= '0;
            cycle_cnt  <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_frame) begin
                state     <= RUN;
                pix_cnt   <= '0;
                col       <= '0;
                row       <= '0;
                checksum  <= '0;
                pix_min   <= '1;
                pix_max   <= '0;
                cycle_cnt <= '0;
                overrun   <= 1'b0;
                timeout   <= 1'b0;
            end else if (state == RUN) begin
                if (pix_valid) begin
                    pix_cnt  <= pix_cnt + 1'b1;
                    checksum <= checksum + SUM_W'(pix_data);
                    if (pix_data < pix_min)
                        pix_min <= pix_data;
                    if (pix_data > pix_max)
                        pix_max <= pix_data;
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                // Frame end takes priority over a coincident timeout and freezes cycle_cnt.
                if (last_pix) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                    col        <= '0;
                    row        <= '0;
                end else if (cycle_cnt == LAST_CYC) begin
                    state   <= IDLE;
                    timeout <= 1'b1;
                end else begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
            end else begin
                if (pix_valid)
                    overrun <= 1'b1;
                if (state == DONE)
                    state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_medfilter_frame_monitor.sv
// Directed bench for medfilter_frame_monitor on a 4x2 frame: one-shot, timeout and continuous variants.
module tb_medfilter_frame_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn = 1'b0;
    int         vectors = 0;
    int         errors  = 0;

    // one-shot instance
    logic       a_start = 0, a_valid = 0;
    logic [7:0] a_data = 0;
    logic       a_run, a_done, a_busy, a_ovr, a_to;
    logic [7:0] a_cnt, a_min, a_max, a_cyc;
    logic [1:0] a_col;
    logic [0:0] a_row;
    logic [15:0] a_sum;

    // short-timeout instance
    logic       b_start = 0, b_valid = 0;
    logic [7:0] b_data = 0;
    logic       b_run, b_done, b_busy, b_ovr, b_to;
    logic [7:0] b_cnt, b_min, b_max, b_cyc;
    logic [1:0] b_col;
    logic [0:0] b_row;
    logic [15:0] b_sum;

    // continuous instance
    logic       c_start = 0, c_valid = 0;
    logic [7:0] c_data = 0;
    logic       c_run, c_done, c_busy, c_ovr, c_to;
    logic [7:0] c_cnt, c_min, c_max, c_cyc;
    logic [1:0] c_col;
    logic [0:0] c_row;
    logic [15:0] c_sum;

    medfilter_frame_monitor #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .CNT_W(8), .SUM_W(16),
        .CYC_W(8), .TIMEOUT(64), .CONTINUOUS(0)) u_dut (
        .CLK(clk), .RSTn(rstn), .Start_sig(a_start), .pix_valid(a_valid), .pix_data(a_data),
        .run(a_run), .frame_done(a_done), .busy(a_busy), .pix_cnt(a_cnt), .col(a_col), .row(a_row),
        .checksum(a_sum), .pix_min(a_min), .pix_max(a_max), .cycle_cnt(a_cyc),
        .overrun(a_ovr), .timeout(a_to));

    medfilter_frame_monitor #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .CNT_W(8), .SUM_W(16),
        .CYC_W(8), .TIMEOUT(10), .CONTINUOUS(0)) u_to (
        .CLK(clk), .RSTn(rstn), .Start_sig(b_start), .pix_valid(b_valid), .pix_data(b_data),
        .run(b_run), .frame_done(b_done), .busy(b_busy), .pix_cnt(b_cnt), .col(b_col), .row(b_row),
        .checksum(b_sum), .pix_min(b_min), .pix_max(b_max), .cycle_cnt(b_cyc),
        .overrun(b_ovr), .timeout(b_to));

    medfilter_frame_monitor #(.IMG_W(4), .IMG_H(2), .DATA_W(8), .CNT_W(8), .SUM_W(16),
        .CYC_W(8), .TIMEOUT(64), .CONTINUOUS(1)) u_cont (
        .CLK(clk), .RSTn(rstn), .Start_sig(c_start), .pix_valid(c_valid), .pix_data(c_data),
        .run(c_run), .frame_done(c_done), .busy(c_busy), .pix_cnt(c_cnt), .col(c_col), .row(c_row),
        .checksum(c_sum), .pix_min(c_min), .pix_max(c_max), .cycle_cnt(c_cyc),
        .overrun(c_ovr), .timeout(c_to));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        vectors++;
        if ({a_run, a_done, a_busy, a_ovr, a_to} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {a_run, a_done, a_busy, a_ovr, a_to});
        end
        vectors++;
        if (a_cnt !== 8'd0 || a_sum !== 16'd0 || a_cyc !== 8'd0 || a_col !== 2'd0 || a_row !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters got cnt=%0d sum=%0d cyc=%0d col=%0d row=%0d want all 0",
                     a_cnt, a_sum, a_cyc, a_col, a_row);
        end
        vectors++;
        if (a_min !== 8'hFF || a_max !== 8'h00) begin
            errors++;
            $display("FAIL reset_minmax got min=%h max=%h want ff 00", a_min, a_max);
        end
        rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        vectors++;
        if (a_run !== 1'b1 || a_cyc !== 8'd0) begin
            errors++;
            $display("FAIL b2b_start got run=%b cyc=%0d want 1 0", a_run, a_cyc);
        end
        for (int i = 1; i <= 8; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(i);
            tick();
            if (a_done === 1'b1) pulses++;
        end
        a_valid = 1'b0;
        vectors++;
        if (pulses !== 1 || a_done !== 1'b1 || a_run !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got pulses=%0d done=%b run=%b want 1 1 0", pulses, a_done, a_run);
        end
        vectors++;
        if (a_cnt !== 8'd8 || a_sum !== 16'd36 || a_min !== 8'd1 || a_max !== 8'd8 || a_cyc !== 8'd7) begin
            errors++;
            $display("FAIL b2b_results got cnt=%0d sum=%0d min=%0d max=%0d cyc=%0d want 8 36 1 8 7",
                     a_cnt, a_sum, a_min, a_max, a_cyc);
        end
        vectors++;
        if (a_col !== 2'd0 || a_row !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pos got col=%0d row=%0d want 0 0", a_col, a_row);
        end
        tick();
        vectors++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_cnt !== 8'd8 || a_sum !== 16'd36) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b done=%b cnt=%0d sum=%0d want 0 0 8 36",
                     a_busy, a_done, a_cnt, a_sum);
        end
    endtask

    task automatic test_every_other();
        int pulses = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(i);
            tick();
            if (a_done === 1'b1) pulses++;
            if (i == 4) begin
                vectors++;
                if (a_row !== 1'b1 || a_col !== 2'd0 || a_cnt !== 8'd4) begin
                    errors++;
                    $display("FAIL gap_wrap got row=%0d col=%0d cnt=%0d want 1 0 4", a_row, a_col, a_cnt);
                end
            end
            if (i == 3) begin
                vectors++;
                if (a_col !== 2'd3 || a_row !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_col got col=%0d row=%0d want 3 0", a_col, a_row);
                end
            end
            a_valid = 1'b0;
            tick();
            if (a_done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 1 || a_sum !== 16'd36 || a_cyc !== 8'd14 || a_busy !== 1'b0 || a_ovr !== 1'b0) begin
            errors++;
            $display("FAIL gap_frame got pulses=%0d sum=%0d cyc=%0d busy=%b ovr=%b want 1 36 14 0 0",
                     pulses, a_sum, a_cyc, a_busy, a_ovr);
        end
    endtask

    task automatic test_overrun();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'd99;
        tick();
        a_valid = 1'b0;
        vectors++;
        if (a_ovr !== 1'b1 || a_cnt !== 8'd0 || a_sum !== 16'd0 || a_max !== 8'd0) begin
            errors++;
            $display("FAIL ovr_set got ovr=%b cnt=%0d sum=%0d max=%0d want 1 0 0 0", a_ovr, a_cnt, a_sum, a_max);
        end
        tick();
        vectors++;
        if (a_ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky got %b want 1", a_ovr);
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        vectors++;
        if (a_ovr !== 1'b0 || a_run !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%b run=%b want 0 1", a_ovr, a_run);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 1; i <= 5; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(i * 3);
            tick();
        end
        a_valid = 1'b0;
        vectors++;
        if (a_cnt !== 8'd5 || a_sum !== 16'd45 || a_col !== 2'd1 || a_row !== 1'b1) begin
            errors++;
            $display("FAIL mid_partial got cnt=%0d sum=%0d col=%0d row=%0d want 5 45 1 1",
                     a_cnt, a_sum, a_col, a_row);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        vectors++;
        if (a_run !== 1'b0 || a_busy !== 1'b0 || a_cnt !== 8'd0 || a_sum !== 16'd0 ||
            a_min !== 8'hFF || a_max !== 8'h00 || a_cyc !== 8'd0 || a_col !== 2'd0 || a_row !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got run=%b busy=%b cnt=%0d sum=%0d min=%h max=%h cyc=%0d want 0 0 0 0 ff 00 0",
                     a_run, a_busy, a_cnt, a_sum, a_min, a_max, a_cyc);
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(10 + i);
            tick();
        end
        a_valid = 1'b0;
        vectors++;
        if (a_done !== 1'b1 || a_cnt !== 8'd8 || a_sum !== 16'd108 || a_min !== 8'd10 || a_max !== 8'd17) begin
            errors++;
            $display("FAIL mid_clean got done=%b cnt=%0d sum=%0d min=%0d max=%0d want 1 8 108 10 17",
                     a_done, a_cnt, a_sum, a_min, a_max);
        end
        tick();
    endtask

    task automatic test_timeout();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            b_valid = (i <= 3);
            b_data  = 8'(i * 2);
            tick();
        end
        b_valid = 1'b0;
        vectors++;
        if (b_run !== 1'b1 || b_to !== 1'b0 || b_cyc !== 8'd9) begin
            errors++;
            $display("FAIL to_before got run=%b to=%b cyc=%0d want 1 0 9", b_run, b_to, b_cyc);
        end
        tick();
        vectors++;
        if (b_to !== 1'b1 || b_run !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL to_hit got to=%b run=%b busy=%b done=%b want 1 0 0 0", b_to, b_run, b_busy, b_done);
        end
        tick();
        vectors++;
        if (b_cnt !== 8'd3 || b_sum !== 16'd12 || b_min !== 8'd2 || b_max !== 8'd6 || b_to !== 1'b1) begin
            errors++;
            $display("FAIL to_hold got cnt=%0d sum=%0d min=%0d max=%0d to=%b want 3 12 2 6 1",
                     b_cnt, b_sum, b_min, b_max, b_to);
        end
    endtask

    task automatic test_continuous();
        int pulses = 0;
        int first  = -1;
        int second = -1;
        c_start = 1'b1;
        c_data  = 8'd255;
        tick();
        for (int t = 1; t <= 18; t++) begin
            c_valid = (t != 9 && t <= 17);
            if (t == 17) c_start = 1'b0;
            tick();
            if (c_done === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
                else second = t;
            end
            if (t == 9) begin
                vectors++;
                if (c_run !== 1'b1 || c_sum !== 16'd0 || c_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL cont_rearm got run=%b sum=%0d cnt=%0d want 1 0 0", c_run, c_sum, c_cnt);
                end
            end
            if (t == 17) begin
                vectors++;
                if (c_sum !== 16'd2040 || c_min !== 8'd255 || c_max !== 8'd255 || c_cnt !== 8'd8) begin
                    errors++;
                    $display("FAIL cont_frame2 got sum=%0d min=%0d max=%0d cnt=%0d want 2040 255 255 8",
                             c_sum, c_min, c_max, c_cnt);
                end
            end
        end
        c_valid = 1'b0;
        vectors++;
        if (pulses !== 2 || second - first !== 9) begin
            errors++;
            $display("FAIL cont_pulses got pulses=%0d gap=%0d want 2 9", pulses, second - first);
        end
        vectors++;
        if (c_busy !== 1'b0 || c_ovr !== 1'b0 || c_to !== 1'b0) begin
            errors++;
            $display("FAIL cont_end got busy=%b ovr=%b to=%b want 0 0 0", c_busy, c_ovr, c_to);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_every_other();
        test_overrun();
        test_reset_midframe();
        test_timeout();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

endmodule
